// File: rtl/safecrack_supervisor.sv
// Supervisor for the safecrack lock FSM: gates buttons, owns the combination,
// counts consecutive failures and enforces a timed lockout.
module safecrack_supervisor #(
  parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
  parameter int unsigned LOCKOUT_S    = 10,
  parameter int unsigned MAX_FAILS    = 3,
  parameter logic [5:0]  DEFAULT_CODE = 6'b10_01_00
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] btn,
  input  logic       prog_req,
  input  logic       lock_success,
  input  logic       lock_error,
  output logic [2:0] btn_to_lock,
  output logic [5:0] code,
  output logic       lockout,
  output logic [1:0] fail_cnt,
  output logic       prog_active,
  output logic [1:0] prog_digit
);

  localparam int unsigned LOCK_CYC   = LOCKOUT_S * CLK_FREQ_HZ;
  localparam int unsigned TIMER_W    = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCK_CYC - 1);
  localparam logic [1:0] MAX_F = 2'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PROG    = 2'b01,
    ST_LOCKOUT = 2'b10
  } state_t;

  state_t               state, state_nxt;
  logic [5:0]           code_nxt;
  logic [5:0]           shadow, shadow_nxt;
  logic [2:0]           btn_lock_nxt;
  logic [1:0]           fail_nxt;
  logic [1:0]           digit_nxt;
  logic                 auth, auth_nxt;
  logic                 release_wait, rw_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic [2:0]           btn_prev;
  logic                 prog_prev;
  logic [2:0]           press;
  logic                 prog_rise;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    if (v >= MAX_F) return MAX_F;
    return v + 2'd1;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [2:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    return 2'd2;
  endfunction

  assign press       = ~btn & ~btn_prev;
  assign prog_rise   = prog_req & ~prog_prev;
  assign lockout     = (state == ST_LOCKOUT);
  assign prog_active = (state == ST_PROG);

  always_comb begin
    state_nxt    = state;
    code_nxt     = code;
    shadow_nxt   = shadow;
    btn_lock_nxt = 3'b111;
    fail_nxt     = fail_cnt;
    digit_nxt    = prog_digit;
    auth_nxt     = auth;
    rw_nxt       = release_wait;
    timer_nxt    = timer;
    // A fully released keypad ends masking; an exit below re-arms it.
    if (btn == 3'b111) rw_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!release_wait) btn_lock_nxt = btn;
        if (lock_error) begin
          fail_nxt = sat_inc(fail_cnt);
          auth_nxt = 1'b0;
          if (sat_inc(fail_cnt) == MAX_F) begin
            state_nxt = ST_LOCKOUT;
            timer_nxt = TIMER_LOAD;
          end
        end else begin
          if (lock_success) begin
            fail_nxt = 2'd0;
            auth_nxt = 1'b1;
          end
          if (prog_rise && auth) begin
            state_nxt = ST_PROG;
            digit_nxt = 2'd0;
          end
        end
      end
      ST_PROG: begin
        if (!prog_req) begin
          state_nxt = ST_IDLE;
          auth_nxt  = 1'b0;
          digit_nxt = 2'd0;
          rw_nxt    = 1'b1;
        end else if ($onehot(press)) begin
          case (prog_digit)
            2'd0: begin
              shadow_nxt[1:0] = onehot_idx(press);
              digit_nxt       = 2'd1;
            end
            2'd1: begin
              shadow_nxt[3:2] = onehot_idx(press);
              digit_nxt       = 2'd2;
            end
            default: begin
              // Whole combination switches at once so the lock never sees a mix.
              code_nxt  = {onehot_idx(press), shadow[3:0]};
              auth_nxt  = 1'b0;
              fail_nxt  = 2'd0;
              digit_nxt = 2'd0;
              state_nxt = ST_IDLE;
              rw_nxt    = 1'b1;
            end
          endcase
        end
      end
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_nxt = ST_IDLE;
          fail_nxt  = 2'd0;
          rw_nxt    = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        fail_nxt  = 2'd0;
        digit_nxt = 2'd0;
        auth_nxt  = 1'b0;
        rw_nxt    = 1'b0;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      code         <= DEFAULT_CODE;
      btn_to_lock  <= 3'b111;
      fail_cnt     <= 2'd0;
      prog_digit   <= 2'd0;
      auth         <= 1'b0;
      release_wait <= 1'b0;
      timer        <= '0;
      btn_prev     <= 3'b000;
      prog_prev    <= 1'b0;
    end else begin
      state        <= state_nxt;
      code         <= code_nxt;
      btn_to_lock  <= btn_lock_nxt;
      fail_cnt     <= fail_nxt;
      prog_digit   <= digit_nxt;
      auth         <= auth_nxt;
      release_wait <= rw_nxt;
      timer        <= timer_nxt;
      btn_prev     <= ~btn;
      prog_prev    <= prog_req;
    end
  end

  // Shadow digits are only read after being written in the same PROG session.
  always_ff @(posedge clk) begin
    shadow <= shadow_nxt;
  end

endmodule

// File: tb/tb_safecrack_supervisor.sv
// Bench for safecrack_supervisor: directed scenarios then random traffic,
// each cycle compared against a count/queue based reference model.
module tb_safecrack_supervisor;

  localparam int unsigned CLK_HZ   = 10;
  localparam int unsigned LOCK_S   = 2;
  localparam int unsigned MAXF     = 3;
  localparam int          LOCK_CYC = CLK_HZ * LOCK_S;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] btn;
  logic       prog_req, lock_success, lock_error;
  logic [2:0] btn_to_lock;
  logic [5:0] code;
  logic       lockout, prog_active;
  logic [1:0] fail_cnt, prog_digit;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         m_lock_left;
  int         m_errors;
  bit         m_in_prog, m_auth, m_masked, m_prev_prog;
  logic [2:0] m_prev_btn, m_btn_out;
  logic [5:0] m_code;
  int         m_digits[$];

  safecrack_supervisor #(
    .CLK_FREQ_HZ (CLK_HZ),
    .LOCKOUT_S   (LOCK_S),
    .MAX_FAILS   (MAXF),
    .DEFAULT_CODE(6'b10_01_00)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn         (btn),
    .prog_req    (prog_req),
    .lock_success(lock_success),
    .lock_error  (lock_error),
    .btn_to_lock (btn_to_lock),
    .code        (code),
    .lockout     (lockout),
    .fail_cnt    (fail_cnt),
    .prog_active (prog_active),
    .prog_digit  (prog_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock_left = 0;
    m_errors    = 0;
    m_in_prog   = 0;
    m_auth      = 0;
    m_masked    = 0;
    m_prev_prog = 0;
    m_prev_btn  = 3'b000;
    m_btn_out   = 3'b111;
    m_code      = 6'b10_01_00;
    m_digits.delete();
  endtask

  task automatic model_step(input logic [2:0] b, input logic pr, input logic s, input logic e);
    logic [2:0] pressed;
    bit         rise;
    pressed = ~b & ~m_prev_btn;
    rise    = pr && !m_prev_prog;
    m_btn_out = (!m_in_prog && m_lock_left == 0 && !m_masked) ? b : 3'b111;
    if (b == 3'b111) m_masked = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin
        m_errors = 0;
        m_masked = 1;
      end
    end else if (m_in_prog) begin
      if (!pr) begin
        m_in_prog = 0;
        m_auth    = 0;
        m_masked  = 1;
        m_digits.delete();
      end else if ($countones(pressed) == 1) begin
        m_digits.push_back($clog2(pressed));
        if (m_digits.size() == 3) begin
          m_code    = {2'(m_digits[2]), 2'(m_digits[1]), 2'(m_digits[0])};
          m_auth    = 0;
          m_errors  = 0;
          m_in_prog = 0;
          m_masked  = 1;
          m_digits.delete();
        end
      end
    end else begin
      if (e) begin
        m_errors = (m_errors + 1 > MAXF) ? MAXF : m_errors + 1;
        m_auth   = 0;
        if (m_errors == MAXF) m_lock_left = LOCK_CYC;
      end else begin
        if (rise && m_auth) m_in_prog = 1;
        if (s) begin
          m_errors = 0;
          m_auth   = 1;
        end
      end
    end
    m_prev_btn  = ~b;
    m_prev_prog = pr;
  endtask

  task automatic compare_all();
    chk("btn_to_lock", 32'(btn_to_lock), 32'(m_btn_out));
    chk("code",        32'(code),        32'(m_code));
    chk("lockout",     32'(lockout),     32'(m_lock_left > 0));
    chk("fail_cnt",    32'(fail_cnt),    32'(m_errors));
    chk("prog_active", 32'(prog_active), 32'(m_in_prog));
    chk("prog_digit",  32'(prog_digit),  32'(m_digits.size()));
  endtask

  task automatic cycle(input logic [2:0] b, input logic pr, input logic s, input logic e);
    btn          = b;
    prog_req     = pr;
    lock_success = s;
    lock_error   = e;
    @(posedge clk);
    if (!rstn) model_reset();
    else model_step(b, pr, s, e);
    #1;
    compare_all();
    lock_success = 1'b0;
    lock_error   = 1'b0;
  endtask

  initial begin
    int  n;
    logic pr_r;
    model_reset();
    rstn = 1'b0;
    btn = 3'b000; prog_req = 1'b0; lock_success = 1'b0; lock_error = 1'b0;

    // 1. Reset values
    cycle(3'b000, 0, 0, 0);
    cycle(3'b000, 0, 0, 0);
    chk("t1_btn", 32'(btn_to_lock), 32'h7);
    chk("t1_code", 32'(code), 32'b100100);
    chk("t1_zero", 32'({lockout, fail_cnt, prog_active, prog_digit}), 32'h0);
    rstn = 1'b1;
    repeat (2) cycle(3'b111, 0, 0, 0);

    // 2. Three errors -> lockout of 20 cycles
    for (int k = 1; k <= 3; k++) begin
      cycle(3'b111, 0, 0, 1);
      chk("t2_fail_cnt", 32'(fail_cnt), 32'(k));
      if (k < 3) repeat (4) cycle(3'b111, 0, 0, 0);
    end
    chk("t2_lockout_on", 32'(lockout), 32'h1);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      cycle(3'b111, 0, 0, 0);
      if (!lockout) break;
      n++;
    end
    chk("t2_lock_len", 32'(n), 32'(LOCK_CYC));
    chk("t2_fail_clr", 32'(fail_cnt), 32'h0);
    cycle(3'b111, 0, 0, 0);
    cycle(3'b110, 0, 0, 0);
    chk("t2_pass", 32'(btn_to_lock), 32'b110);
    cycle(3'b111, 0, 0, 0);

    // 3. Success then program 2,0,1
    cycle(3'b111, 0, 1, 0);
    cycle(3'b111, 1, 0, 0);
    chk("t3_prog_on", 32'(prog_active), 32'h1);
    chk("t3_digit0", 32'(prog_digit), 32'h0);
    cycle(3'b011, 1, 0, 0);
    chk("t3_digit1", 32'(prog_digit), 32'h1);
    cycle(3'b111, 1, 0, 0);
    cycle(3'b110, 1, 0, 0);
    chk("t3_digit2", 32'(prog_digit), 32'h2);
    cycle(3'b111, 1, 0, 0);
    cycle(3'b101, 1, 0, 0);
    chk("t3_code", 32'(code), 32'b010010);
    chk("t3_prog_off", 32'(prog_active), 32'h0);
    cycle(3'b111, 0, 0, 0);
    cycle(3'b111, 0, 0, 0);

    // 4. Unauthorised prog edges
    cycle(3'b111, 1, 0, 0);
    chk("t4_noprog", 32'(prog_active), 32'h0);
    cycle(3'b110, 1, 0, 0);
    chk("t4_pass", 32'(btn_to_lock), 32'b110);
    cycle(3'b111, 0, 1, 0);
    cycle(3'b111, 0, 0, 1);
    cycle(3'b111, 1, 0, 0);
    chk("t4_err_noprog", 32'(prog_active), 32'h0);
    cycle(3'b111, 0, 0, 0);

    // 5. Abort after one digit
    cycle(3'b111, 0, 1, 0);
    cycle(3'b111, 1, 0, 0);
    chk("t5_prog_on", 32'(prog_active), 32'h1);
    cycle(3'b011, 1, 0, 0);
    cycle(3'b111, 1, 0, 0);
    cycle(3'b111, 0, 0, 0);
    chk("t5_code_kept", 32'(code), 32'b010010);
    chk("t5_idle", 32'(prog_active), 32'h0);
    cycle(3'b111, 1, 0, 0);
    chk("t5_reedge", 32'(prog_active), 32'h0);
    cycle(3'b111, 0, 0, 0);

    // 6. Button held across end of lockout; simultaneous error+success
    for (int k = 0; k < 3; k++) cycle(3'b111, 0, 0, 1);
    for (int i = 0; i < LOCK_CYC + 4; i++) begin
      cycle(3'b110, 0, 0, 0);
      chk("t6_masked", 32'(btn_to_lock), 32'h7);
    end
    cycle(3'b111, 0, 0, 0);
    cycle(3'b101, 0, 0, 0);
    chk("t6_pass", 32'(btn_to_lock), 32'b101);
    cycle(3'b111, 0, 1, 0);
    cycle(3'b111, 0, 1, 1);
    chk("t6_both_fail", 32'(fail_cnt), 32'h1);
    cycle(3'b111, 1, 0, 0);
    chk("t6_both_noauth", 32'(prog_active), 32'h0);
    cycle(3'b111, 0, 0, 0);

    // 7. Reset mid-PROG restores the default code
    cycle(3'b111, 0, 1, 0);
    cycle(3'b111, 1, 0, 0);
    cycle(3'b110, 1, 0, 0);
    rstn = 1'b0;
    cycle(3'b111, 1, 0, 0);
    chk("t7_code", 32'(code), 32'b100100);
    chk("t7_prog", 32'(prog_active), 32'h0);
    rstn = 1'b1;
    cycle(3'b111, 0, 0, 0);

    // Random traffic
    pr_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] b;
      logic       s, e;
      rstn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) pr_r = ~pr_r;
      b = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 24) == 0);
      cycle(b, pr_r, s, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
